count_sched: RTL and testbench
==============================

Name: count_sched

Overview:
- Run/pause/abort controller that sequences an embedded WIDTH-bit up-counter datapath for the lab timing experiments.
- Latches a terminal value and mode on start, then counts 0..term.
- Signals terminal count as a one-cycle pulse and either stops (one-shot) or wraps (periodic).
- Sits between push-button/switch logic and display/LED consumers.

Parameters:
- WIDTH, 4, counter and terminal-value width.
- DEFAULT_TERM, 15, value loaded into the terminal register on reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  arm/launch request; honoured only in IDLE or DONE.
- pause  input  1  level; while high in RUN/PAUSE the count freezes.
- abort  input  1  return to IDLE from any state, count cleared.
- mode  input  1  0 = one-shot, 1 = periodic; sampled with start.
- term  input  WIDTH  terminal count; sampled with start.
- count  output  WIDTH  current counter value.
- tc  output  1  one-cycle pulse after the terminal count is reached.
- busy  output  1  high in RUN or PAUSE.
- done  output  1  high while in DONE.
- state  output  2  IDLE=00, RUN=01, PAUSE=10, DONE=11.

Behaviour:
- All outputs are registered.
- reset low (asynchronous, no clock needed):
  - state=IDLE, count=0, tc=0, busy=0, done=0.
  - term_q=DEFAULT_TERM, mode_q=0.
- Priority at every edge: abort > start (IDLE/DONE only) > pause > terminal/increment.
- tc defaults to 0 every cycle unless set by the terminal rule below.
- IDLE:
  - start=1 -> term_q<=term, mode_q<=mode, count<=0, state RUN.
  - Otherwise hold.
- RUN:
  - abort=1 -> IDLE, count<=0.
  - pause=1 -> PAUSE, count held.
  - count==term_q: tc<=1.
    - mode_q=1: count<=0, stay RUN.
    - mode_q=0: state DONE, count held at term_q.
  - Else count<=count+1.
- PAUSE:
  - abort=1 -> IDLE, count<=0.
  - pause=0 -> RUN; counting continues from the held value on the next edge.
  - The terminal check is not made in PAUSE.
- DONE:
  - done=1, busy=0, count holds term_q.
  - start=1 -> re-arm as from IDLE: new term/mode latched, count<=0, RUN.
  - abort=1 -> IDLE, count<=0.
- start in RUN/PAUSE is ignored.
- term/mode changes after start are ignored until the next start.
- Timing, with start sampled at edge k:
  - count=n after edge k+n.
  - tc high during the cycle after edge k+term+1.
  - Periodic period = term+1 cycles.
- term=0:
  - one-shot: DONE and tc one edge after RUN entry.
  - periodic: tc high every cycle, count stays 0.
- term=2^WIDTH-1 periodic: count wraps 15->0 with tc; no overflow beyond term_q.
- abort and terminal count in the same cycle: abort wins, no tc.
- pause and terminal count in the same cycle: pause wins, no tc; tc fires on the first RUN edge after resume.
- reset asserted mid-count clears immediately; the first edge after release behaves as IDLE.

Test Plan:
- Reset then start, mode=0, term=5 -> count 1,2,3,4,5; next edge state=DONE, done=1, tc pulses one cycle, count stays 5, busy 0.
- Periodic, term=3, run 12 cycles -> count 0,1,2,3,0,...; tc high once per 4 cycles (3 pulses); state stays 01.
- Periodic, term=7, pause high 3 cycles at count=4 -> state=10, count frozen at 4; after release, 5,6,7 then wrap with tc.
- One-shot, term=9; abort at count=6 -> state IDLE, count 0, no tc, busy 0. Separately, abort asserted on the terminal cycle -> no tc.
- In DONE (term=2), start with term=0, mode=0 -> RUN for one edge, then DONE with tc. Start pulses during RUN are ignored (count unaffected).
- reset driven low asynchronously mid-RUN (count=3) between edges -> count=0, state=00 without a clock edge. After release, term_q=15 (default) is not used until start latches a new term.

Source files
------------

// File: rtl/count_sched_if.sv
// Control/status bundle for count_sched: run controls in, counter and status out.
interface count_sched_if #(parameter int WIDTH = 4);
    logic             start;
    logic             pause;
    logic             abort;
    logic             mode;
    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             busy;
    logic             done;
    logic [1:0]       state;

    modport master (
        output start, pause, abort, mode, term,
        input  count, tc, busy, done, state
    );

    modport slave (
        input  start, pause, abort, mode, term,
        output count, tc, busy, done, state
    );
endinterface

// File: rtl/count_sched.sv
// Run/pause/abort sequencer around a WIDTH-bit up-counter; one-shot or periodic to a latched terminal.
// Latency: all outputs registered, one edge after the controlling input; no backpressure (pause freezes the count).
module count_sched #(
    parameter int WIDTH        = 4,
    parameter int DEFAULT_TERM = 15
) (
    input logic         clk,
    input logic         reset,
    count_sched_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] RUN   = 2'b01;
    localparam logic [1:0] PAUSE = 2'b10;
    localparam logic [1:0] DONE  = 2'b11;

    localparam logic [WIDTH-1:0] TERM_RST = WIDTH'(DEFAULT_TERM);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] term_q, term_d;
    logic             mode_q, mode_d;
    logic             tc_q, tc_d;
    logic             busy_q, done_q;

    // Priority: abort > start (IDLE/DONE) > pause > terminal/increment.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        term_d  = term_q;
        mode_d  = mode_q;
        tc_d    = 1'b0;
        if (bus.abort) begin
            state_d = IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        term_d  = bus.term;
                        mode_d  = bus.mode;
                        count_d = '0;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (bus.pause) begin
                        state_d = PAUSE;
                    end else if (count_q == term_q) begin
                        tc_d = 1'b1;
                        if (mode_q) begin
                            count_d = '0;
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        count_d = count_q + WIDTH'(1);
                    end
                end
                PAUSE: begin
                    // Resume edge only changes state; counting restarts on the following edge.
                    if (!bus.pause) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
            term_q  <= TERM_RST;
            mode_q  <= 1'b0;
            tc_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            term_q  <= term_d;
            mode_q  <= mode_d;
            tc_q    <= tc_d;
            busy_q  <= (state_d == RUN) || (state_d == PAUSE);
            done_q  <= (state_d == DONE);
        end
    end

    assign bus.count = count_q;
    assign bus.tc    = tc_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.state = state_q;
endmodule

// File: tb/tb_count_sched.sv
// Self-checking bench for count_sched: directed scenarios then random stimulus against a behavioural model.
module tb_count_sched;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    count_sched_if #(.WIDTH(4)) bus ();

    count_sched #(.WIDTH(4), .DEFAULT_TERM(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: activity flags plus latched settings.
    bit m_running, m_paused, m_finished, m_tc, m_periodic;
    int m_cnt, m_term;
    int tc_seen;

    function automatic logic [1:0] m_state();
        if (m_paused)   return 2'd2;
        if (m_running)  return 2'd1;
        if (m_finished) return 2'd3;
        return 2'd0;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".count"}, 8'(bus.count), 8'(m_cnt));
        chk({tag, ".tc"},    8'(bus.tc),    8'(m_tc));
        chk({tag, ".busy"},  8'(bus.busy),  8'(m_running || m_paused));
        chk({tag, ".done"},  8'(bus.done),  8'(m_finished));
        chk({tag, ".state"}, 8'(bus.state), 8'(m_state()));
    endtask

    task automatic model_reset();
        m_running = 0; m_paused = 0; m_finished = 0; m_tc = 0;
        m_cnt = 0; m_term = 15; m_periodic = 0;
    endtask

    task automatic model_edge(input bit s, input bit p, input bit a, input bit md, input int t);
        m_tc = 0;
        if (a) begin
            m_running = 0; m_paused = 0; m_finished = 0; m_cnt = 0;
        end else if (!m_running && !m_paused && s) begin
            m_term = t; m_periodic = md; m_cnt = 0;
            m_running = 1; m_finished = 0;
        end else if (m_running) begin
            if (p) begin
                m_running = 0; m_paused = 1;
            end else if (m_cnt == m_term) begin
                m_tc = 1;
                if (m_periodic) m_cnt = 0;
                else begin m_running = 0; m_finished = 1; end
            end else begin
                m_cnt = m_cnt + 1;
            end
        end else if (m_paused && !p) begin
            m_paused = 0; m_running = 1;
        end
    endtask

    task automatic step(input string tag, input bit s, input bit p, input bit a, input bit md, input int t);
        @(negedge clk);
        bus.start = s; bus.pause = p; bus.abort = a; bus.mode = md; bus.term = 4'(t);
        @(posedge clk);
        model_edge(s, p, a, md, t);
        #1;
        if (bus.tc === 1'b1) tc_seen++;
        chk_all(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 0, 0, 0, $urandom_range(0, 1), $urandom_range(0, 15));
    endtask

    initial begin
        errors = 0; checks = 0; tc_seen = 0;
        bus.start = 0; bus.pause = 0; bus.abort = 0; bus.mode = 0; bus.term = 4'd0;
        reset = 1'b0;
        model_reset();
        #3;
        chk_all("reset");
        @(negedge clk);
        reset = 1'b1;
        idle("idle_after_reset", 2);

        // One-shot term=5
        step("os5_start", 1, 0, 0, 0, 5);
        idle("os5_run", 7);
        chk("os5_count_final", 8'(bus.count), 8'd5);

        // Periodic term=3 from DONE, 12 cycles -> 3 tc pulses
        step("per3_start", 1, 0, 0, 1, 3);
        tc_seen = 0;
        idle("per3_run", 12);
        chk("per3_tc_pulses", 8'(tc_seen), 8'd3);

        // Periodic term=7 with a 3-cycle pause at count=4
        step("per7_abort", 0, 0, 1, 0, 0);
        step("per7_start", 1, 0, 0, 1, 7);
        idle("per7_run", 4);
        for (int i = 0; i < 3; i++) step("per7_pause", 0, 1, 0, 0, 0);
        chk("per7_frozen", 8'(bus.count), 8'd4);
        idle("per7_resume", 6);

        // One-shot term=9 aborted at count=6, then abort on the terminal cycle
        step("os9_start", 1, 0, 0, 0, 9);
        idle("os9_run", 6);
        step("os9_abort", 0, 0, 1, 0, 0);
        step("os9b_start", 1, 0, 0, 0, 9);
        idle("os9b_run", 9);
        step("os9b_abort_tc", 0, 0, 1, 0, 0);
        chk("os9b_no_tc", 8'(bus.tc), 8'd0);

        // term=2 to DONE, then re-arm with term=0
        step("os2_start", 1, 0, 0, 0, 2);
        idle("os2_run", 4);
        step("os0_start", 1, 0, 0, 0, 0);
        step("os0_done", 0, 0, 0, 0, 0);
        chk("os0_tc", 8'(bus.tc), 8'd1);

        // Start pulses during RUN are ignored
        step("ign_start", 1, 0, 0, 0, 9);
        for (int i = 0; i < 3; i++) step("ign_run", 1, 0, 0, 1, 1);
        chk("ign_count", 8'(bus.count), 8'd3);

        // Periodic term=0 and term=15 wrap
        step("p0_abort", 0, 0, 1, 0, 0);
        step("p0_start", 1, 0, 0, 1, 0);
        idle("p0_run", 4);
        step("p15_abort", 0, 0, 1, 0, 0);
        step("p15_start", 1, 0, 0, 1, 15);
        idle("p15_run", 20);

        // Pause on the terminal cycle defers tc until after resume
        step("pt_abort", 0, 0, 1, 0, 0);
        step("pt_start", 1, 0, 0, 0, 2);
        idle("pt_run", 2);
        step("pt_pause", 0, 1, 0, 0, 0);
        idle("pt_resume", 3);

        // Asynchronous reset mid-RUN at count=3
        step("ar_start", 1, 0, 0, 0, 9);
        idle("ar_run", 3);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk_all("async_reset");
        @(negedge clk);
        reset = 1'b1;
        idle("ar_idle", 3);
        step("ar_restart", 1, 0, 0, 0, 2);
        idle("ar_rerun", 4);

        // Randomised stimulus
        for (int i = 0; i < 500; i++) begin
            bit s, p, a, md;
            int t;
            s  = ($urandom_range(0, 7) == 0);
            p  = ($urandom_range(0, 5) == 0);
            a  = ($urandom_range(0, 39) == 0);
            md = 1'($urandom_range(0, 1));
            t  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 15);
            step("rand", s, p, a, md, t);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
